frame_align_ctrl: RTL

FRAME_ALIGN_CTRL -- requirements
Module: frame_align_ctrl

---
 rtl/adc_pkg.sv | 16 +
 rtl/frame_align_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/adc_pkg.sv
// Shared ADC-interface definitions: frame-alignment state encoding and the
// expected FCO word.
package adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_LOCKED,
    ST_FAIL
  } align_state_t;

  localparam logic [7:0] FCO_PATTERN = 8'hF0;

endpackage

// File: rtl/frame_align_ctrl.sv
// Frame alignment controller: issues bitslip pulses until the deserialized FCO
// word matches PATTERN, then monitors lock and realigns after repeated misses.
module frame_align_ctrl
  import adc_pkg::*;
#(
  parameter logic [7:0]  PATTERN      = FCO_PATTERN,
  parameter int unsigned SETTLE_CYC   = 4,
  parameter int unsigned LOCK_MATCHES = 16,
  parameter int unsigned MISS_LIMIT   = 4,
  parameter int unsigned MAX_SLIPS    = 8
) (
  input  logic       CLKDIV,
  input  logic       RST,
  input  logic       en,
  input  logic [7:0] frm_data,
  output logic       bitslip,
  output logic       locked,
  output logic       align_fail,
  output logic [3:0] slip_cnt,
  output logic [7:0] relock_cnt
);

  localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned MW = $clog2(LOCK_MATCHES + 1);
  localparam int unsigned XW = $clog2(MISS_LIMIT + 1);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [MW-1:0] MATCH_LAST  = MW'(LOCK_MATCHES - 1);
  localparam logic [XW-1:0] MISS_LAST   = XW'(MISS_LIMIT - 1);
  localparam logic [3:0]    SLIP_MAX    = 4'(MAX_SLIPS);

  align_state_t  state, state_n;
  logic [SW-1:0] settle_cnt, settle_n;
  logic [MW-1:0] match_cnt, match_n;
  logic [XW-1:0] miss_cnt, miss_n;
  logic [3:0]    slip_n;
  logic [7:0]    relock_n;
  logic          match;

  assign match = (frm_data == PATTERN);

  always_comb begin
    state_n  = state;
    settle_n = settle_cnt;
    match_n  = match_cnt;
    miss_n   = miss_cnt;
    slip_n   = slip_cnt;
    relock_n = relock_cnt;
    if (!en) begin
      state_n = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_n  = ST_SETTLE;
          slip_n   = '0;
          settle_n = '0;
          match_n  = '0;
          miss_n   = '0;
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state_n  = ST_CHECK;
            settle_n = '0;
          end else begin
            settle_n = settle_cnt + 1'b1;
          end
        end
        ST_CHECK: begin
          if (match) begin
            match_n = match_cnt + 1'b1;
            if (match_cnt == MATCH_LAST) begin
              state_n = ST_LOCKED;
              miss_n  = '0;
            end
          end else begin
            match_n = '0;
            // slip_cnt counts the pulse being issued, so it tops out at MAX_SLIPS
            if (slip_cnt < SLIP_MAX) begin
              state_n = ST_SLIP;
              slip_n  = slip_cnt + 1'b1;
            end else begin
              state_n = ST_FAIL;
            end
          end
        end
        ST_SLIP: begin
          state_n  = ST_SETTLE;
          settle_n = '0;
        end
        ST_LOCKED: begin
          if (match) begin
            miss_n = '0;
          end else if (miss_cnt == MISS_LAST) begin
            state_n  = ST_SETTLE;
            miss_n   = '0;
            settle_n = '0;
            match_n  = '0;
            slip_n   = '0;
            if (relock_cnt != '1) relock_n = relock_cnt + 1'b1;
          end else begin
            miss_n = miss_cnt + 1'b1;
          end
        end
        ST_FAIL: ;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Status outputs are registered from the next state so they change on the
  // same edge as the state itself.
  always_ff @(posedge CLKDIV or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      slip_cnt   <= '0;
      relock_cnt <= '0;
      bitslip    <= 1'b0;
      locked     <= 1'b0;
      align_fail <= 1'b0;
    end else begin
      state      <= state_n;
      settle_cnt <= settle_n;
      match_cnt  <= match_n;
      miss_cnt   <= miss_n;
      slip_cnt   <= slip_n;
      relock_cnt <= relock_n;
      bitslip    <= (state_n == ST_SLIP);
      locked     <= (state_n == ST_LOCKED);
      align_fail <= (state_n == ST_FAIL);
    end
  end

endmodule
